// File: rtl/traffic_ctrl_multi.sv
// N-approach traffic-light controller: on-chip interval timers, demand-driven
// round-robin green with rest-in-green, all-red clearance and flashing-yellow mode.
module traffic_ctrl_multi #(
    parameter int NUM_DIR  = 4,
    parameter int TW       = 8,
    parameter int GREEN_T  = 20,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 2,
    parameter int FLASH_T  = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       flash,
    input  logic [NUM_DIR-1:0]         req,
    output logic [NUM_DIR-1:0]         red,
    output logic [NUM_DIR-1:0]         yellow,
    output logic [NUM_DIR-1:0]         green,
    output logic [$clog2(NUM_DIR)-1:0] active_dir,
    output logic                       busy
);
    localparam int DW = $clog2(NUM_DIR);
    localparam logic [TW-1:0] GREEN_LAST  = TW'(GREEN_T - 1);
    localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] FLASH_LAST  = TW'(FLASH_T - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ALLRED = 3'd1,
        S_GREEN  = 3'd2,
        S_YELLOW = 3'd3,
        S_FLASH  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [DW-1:0]        cur_q, cur_d;
    logic                 phase_q, phase_d;
    logic [NUM_DIR-1:0]   red_q, yellow_q, green_q;
    logic                 busy_q;
    logic [NUM_DIR-1:0]   own_s;
    logic                 others_waiting_s;

    // Round-robin pick: nearest requesting approach after cur, wrapping; cur+1 when nobody asks.
    function automatic logic [DW-1:0] next_dir(input logic [DW-1:0] cur,
                                               input logic [NUM_DIR-1:0] demand);
        logic [DW-1:0] pick;
        logic [DW-1:0] pos;
        int            idx;
        pick = (cur == DW'(NUM_DIR - 1)) ? DW'(0) : cur + DW'(1);
        for (int k = NUM_DIR; k >= 1; k--) begin
            idx  = int'(cur) + k;
            idx  = (idx >= NUM_DIR) ? idx - NUM_DIR : idx;
            pos  = DW'(idx);
            pick = demand[pos] ? pos : pick;
        end
        return pick;
    endfunction

    // Lamp/busy image of a state, packed as {busy, red, yellow, green}.
    function automatic logic [3*NUM_DIR:0] decode(input state_t st,
                                                  input logic [DW-1:0] cur,
                                                  input logic ph);
        logic [NUM_DIR-1:0] one_hot;
        logic [3*NUM_DIR:0] img;
        one_hot = NUM_DIR'(1) << cur;
        case (st)
            S_IDLE:   img = '0;
            S_ALLRED: img = {1'b1, {NUM_DIR{1'b1}}, {NUM_DIR{1'b0}}, {NUM_DIR{1'b0}}};
            S_GREEN:  img = {1'b1, ~one_hot, {NUM_DIR{1'b0}}, one_hot};
            S_YELLOW: img = {1'b1, ~one_hot, one_hot, {NUM_DIR{1'b0}}};
            S_FLASH:  img = {1'b1, {NUM_DIR{1'b0}}, {NUM_DIR{ph}}, {NUM_DIR{1'b0}}};
            default:  img = {1'b1, {NUM_DIR{1'b1}}, {NUM_DIR{1'b0}}, {NUM_DIR{1'b0}}};
        endcase
        return img;
    endfunction

    assign own_s            = NUM_DIR'(1) << cur_q;
    assign others_waiting_s = |(req & ~own_s);

    // Next-state logic; flash overrides every normal transition.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TW'(1);
        cur_d   = cur_q;
        phase_d = phase_q;
        if (flash) begin
            if (state_q != S_FLASH) begin
                state_d = S_FLASH;
                timer_d = '0;
                phase_d = 1'b1;
            end else if (timer_q == FLASH_LAST) begin
                timer_d = '0;
                phase_d = ~phase_q;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_ALLRED;
                        timer_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ALLRED: begin
                    if (timer_q == ALLRED_LAST) begin
                        state_d = S_GREEN;
                        timer_d = '0;
                        cur_d   = next_dir(cur_q, req);
                    end else begin
                        state_d = S_ALLRED;
                    end
                end
                S_GREEN: begin
                    // Timer parks at the minimum-green mark so rest-in-green never wraps.
                    if (timer_q == GREEN_LAST) begin
                        timer_d = GREEN_LAST;
                        if (others_waiting_s) begin
                            state_d = S_YELLOW;
                            timer_d = '0;
                        end else begin
                            state_d = S_GREEN;
                        end
                    end else begin
                        state_d = S_GREEN;
                    end
                end
                S_YELLOW: begin
                    if (timer_q == YELLOW_LAST) begin
                        state_d = S_ALLRED;
                        timer_d = '0;
                    end else begin
                        state_d = S_YELLOW;
                    end
                end
                S_FLASH: begin
                    state_d = S_ALLRED;
                    timer_d = '0;
                end
                default: begin
                    state_d = S_ALLRED;
                    timer_d = '0;
                end
            endcase
        end
    end

    // State registers; lamp image is registered from the next state so outputs never see inputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            cur_q    <= DW'(NUM_DIR - 1);
            phase_q  <= 1'b0;
            busy_q   <= 1'b0;
            red_q    <= '0;
            yellow_q <= '0;
            green_q  <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cur_q    <= cur_d;
            phase_q  <= phase_d;
            {busy_q, red_q, yellow_q, green_q} <= decode(state_d, cur_d, phase_d);
        end
    end

    assign red        = red_q;
    assign yellow     = yellow_q;
    assign green      = green_q;
    assign busy       = busy_q;
    assign active_dir = cur_q;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Bench for traffic_ctrl_multi: interval-based reference model checked every cycle,
// plus hand-computed lamp snapshots for the directed scenarios.
module tb_traffic_ctrl_multi;
    localparam int N  = 4;
    localparam int GT = 4;
    localparam int YT = 2;
    localparam int AT = 1;
    localparam int FT = 2;

    localparam int M_IDLE   = 0;
    localparam int M_ALLRED = 1;
    localparam int M_GREEN  = 2;
    localparam int M_YELLOW = 3;
    localparam int M_FLASH  = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       flash = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic [3:0] red, yellow, green;
    logic [1:0] active_dir;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    always #5 clk = ~clk;

    traffic_ctrl_multi #(
        .NUM_DIR(N), .TW(8), .GREEN_T(GT), .YELLOW_T(YT), .ALLRED_T(AT), .FLASH_T(FT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .flash(flash), .req(req),
        .red(red), .yellow(yellow), .green(green), .active_dir(active_dir), .busy(busy)
    );

    // Model: which interval we are in, who owns right-of-way, cycles spent in the interval.
    typedef struct packed {
        int mode;
        int dir;
        int age;
    } mdl_t;

    mdl_t mdl = '{mode: M_IDLE, dir: N - 1, age: 0};

    function automatic int pick_next(input int d, input logic [3:0] rq);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (d + k) % N;
            if (((rq >> i) & 4'd1) != 4'd0) return i;
        end
        return (d + 1) % N;
    endfunction

    function automatic bit others_waiting(input int d, input logic [3:0] rq);
        for (int j = 0; j < N; j++) begin
            if (j != d && ((rq >> j) & 4'd1) != 4'd0) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic mdl_t step_model(input mdl_t m, input logic rst_n, input logic st,
                                        input logic fl, input logic [3:0] rq);
        mdl_t n;
        n = m;
        n.age = m.age + 1;
        if (!rst_n) begin
            n.mode = M_IDLE; n.dir = N - 1; n.age = 0;
        end else if (fl) begin
            if (m.mode != M_FLASH) begin n.mode = M_FLASH; n.age = 0; end
        end else begin
            case (m.mode)
                M_IDLE:   if (st) begin n.mode = M_ALLRED; n.age = 0; end
                M_ALLRED: if (m.age + 1 >= AT) begin
                              n.mode = M_GREEN; n.age = 0; n.dir = pick_next(m.dir, rq);
                          end
                M_GREEN:  if (m.age + 1 >= GT && others_waiting(m.dir, rq)) begin
                              n.mode = M_YELLOW; n.age = 0;
                          end
                M_YELLOW: if (m.age + 1 >= YT) begin n.mode = M_ALLRED; n.age = 0; end
                default:  begin n.mode = M_ALLRED; n.age = 0; end
            endcase
        end
        return n;
    endfunction

    // {busy, red, yellow, green} the lamps must show for a model state.
    function automatic logic [12:0] expect_of(input mdl_t m);
        logic [3:0] own;
        own = 4'b0001 << m.dir;
        case (m.mode)
            M_IDLE:   return 13'b0;
            M_ALLRED: return {1'b1, 4'b1111, 4'b0000, 4'b0000};
            M_GREEN:  return {1'b1, ~own, 4'b0000, own};
            M_YELLOW: return {1'b1, ~own, own, 4'b0000};
            default:  return {1'b1, 4'b0000, (((m.age / FT) % 2) == 0) ? 4'b1111 : 4'b0000, 4'b0000};
        endcase
    endfunction

    always @(posedge clk) mdl <= step_model(mdl, reset, start, flash, req);

    task automatic tick(input int n);
        logic [14:0] got, exp;
        repeat (n) begin
            @(negedge clk);
            cycle++;
            checks++;
            got = {busy, red, yellow, green, active_dir};
            exp = {expect_of(mdl), 2'(mdl.dir)};
            if (got !== exp) begin
                failures++;
                $display("FAIL model cyc=%0d got busy/r/y/g/dir=%b required=%b", cycle, got, exp);
            end
        end
    endtask

    task automatic lit(input string name, input logic [3:0] r, input logic [3:0] y,
                       input logic [3:0] g, input logic b);
        checks++;
        if ({busy, red, yellow, green} !== {b, r, y, g}) begin
            failures++;
            $display("FAIL %s cyc=%0d got busy=%b r=%b y=%b g=%b required busy=%b r=%b y=%b g=%b",
                     name, cycle, busy, red, yellow, green, b, r, y, g);
        end
    endtask

    task automatic lit_dir(input string name, input int d);
        checks++;
        if (active_dir !== 2'(d)) begin
            failures++;
            $display("FAIL %s cyc=%0d got active_dir=%0d required %0d", name, cycle, active_dir, d);
        end
    endtask

    initial begin
        // Reset and idle hold
        reset = 1'b0; tick(2);
        reset = 1'b1; tick(1);
        lit("reset_idle", 4'b0000, 4'b0000, 4'b0000, 1'b0); lit_dir("reset_dir", 3);
        tick(10);
        lit("idle_hold", 4'b0000, 4'b0000, 4'b0000, 1'b0); lit_dir("idle_dir", 3);

        // Full demand: round robin 0,1,2,3,0
        req = 4'b1111; start = 1'b1; tick(1); start = 1'b0;
        lit("t2_allred", 4'b1111, 4'b0000, 4'b0000, 1'b1);
        tick(1); lit("t2_g0_first", 4'b1110, 4'b0000, 4'b0001, 1'b1);
        tick(3); lit("t2_g0_last", 4'b1110, 4'b0000, 4'b0001, 1'b1);
        tick(1); lit("t2_y0_first", 4'b1110, 4'b0001, 4'b0000, 1'b1);
        tick(1); lit("t2_y0_last", 4'b1110, 4'b0001, 4'b0000, 1'b1);
        tick(1); lit("t2_clear", 4'b1111, 4'b0000, 4'b0000, 1'b1);
        tick(1); lit("t2_g1", 4'b1101, 4'b0000, 4'b0010, 1'b1);
        tick(7); lit("t2_g2", 4'b1011, 4'b0000, 4'b0100, 1'b1);
        tick(7); lit("t2_g3", 4'b0111, 4'b0000, 4'b1000, 1'b1);
        tick(7); lit("t2_wrap_g0", 4'b1110, 4'b0000, 4'b0001, 1'b1); lit_dir("t2_wrap_dir", 0);

        // Rest-in-green on approach 2, then wrap to 0
        reset = 1'b0; tick(1);
        reset = 1'b1; req = 4'b0100; start = 1'b1; tick(1); start = 1'b0;
        lit("t3_allred", 4'b1111, 4'b0000, 4'b0000, 1'b1);
        tick(1); lit("t3_g2", 4'b1011, 4'b0000, 4'b0100, 1'b1);
        tick(6); lit("t3_rest", 4'b1011, 4'b0000, 4'b0100, 1'b1);
        req = 4'b0101; tick(1); lit("t3_y2", 4'b1011, 4'b0100, 4'b0000, 1'b1);
        tick(2); lit("t3_clear", 4'b1111, 4'b0000, 4'b0000, 1'b1);
        tick(1); lit("t3_g0", 4'b1110, 4'b0000, 4'b0001, 1'b1);

        // Skip an idle approach
        req = 4'b0010; tick(4); lit("t4_y0", 4'b1110, 4'b0001, 4'b0000, 1'b1);
        tick(2); tick(1); lit("t4_g1", 4'b1101, 4'b0000, 4'b0010, 1'b1);
        req = 4'b1001; tick(4); lit("t4_y1", 4'b1101, 4'b0010, 4'b0000, 1'b1);
        tick(2); lit("t4_clear", 4'b1111, 4'b0000, 4'b0000, 1'b1);
        tick(1); lit("t4_g3_skip2", 4'b0111, 4'b0000, 4'b1000, 1'b1);

        // Flash mid-green, then clearance and normal search
        flash = 1'b1; tick(1); lit("t5_flash_on", 4'b0000, 4'b1111, 4'b0000, 1'b1);
        tick(1); lit("t5_flash_on2", 4'b0000, 4'b1111, 4'b0000, 1'b1);
        tick(1); lit("t5_flash_off", 4'b0000, 4'b0000, 4'b0000, 1'b1);
        tick(1); lit("t5_flash_off2", 4'b0000, 4'b0000, 4'b0000, 1'b1);
        tick(1); lit("t5_flash_on3", 4'b0000, 4'b1111, 4'b0000, 1'b1);
        flash = 1'b0; tick(1); lit("t5_exit_clear", 4'b1111, 4'b0000, 4'b0000, 1'b1);
        lit_dir("t5_cur_kept", 3);
        tick(1); lit("t5_g0", 4'b1110, 4'b0000, 4'b0001, 1'b1);

        // Reset mid-yellow
        tick(4); lit("t6_y0", 4'b1110, 4'b0001, 4'b0000, 1'b1);
        reset = 1'b0; tick(1); lit("t6_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        lit_dir("t6_reset_dir", 3);
        reset = 1'b1; tick(3); lit("t6_idle", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        req = 4'b0110; start = 1'b1; tick(1); start = 1'b0;
        lit("t6_allred", 4'b1111, 4'b0000, 4'b0000, 1'b1);
        tick(1); lit("t6_g1", 4'b1101, 4'b0000, 4'b0010, 1'b1);

        // Flash straight out of IDLE
        reset = 1'b0; tick(1); reset = 1'b1;
        flash = 1'b1; tick(1); lit("idle_flash", 4'b0000, 4'b1111, 4'b0000, 1'b1);
        flash = 1'b0; tick(1); lit("idle_flash_exit", 4'b1111, 4'b0000, 4'b0000, 1'b1);
        tick(1); lit("idle_flash_g1", 4'b1101, 4'b0000, 4'b0010, 1'b1);

        // Random soak against the model
        for (int i = 0; i < 400; i++) begin
            if (i % 6 == 0) req = 4'($urandom_range(0, 15));
            if (i % 25 == 0) flash = ($urandom_range(0, 3) == 0);
            start = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 149) != 0);
            tick(1);
        end
        reset = 1'b1; flash = 1'b0; start = 1'b0; tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_ctrl_multi.md
Name: traffic_ctrl_multi

Overview:
- Parametrised N-approach traffic-light controller.
- Successor to the single-approach FSM that relied on external counters:
  - on-chip duration timers
  - demand-driven round-robin green allocation with rest-in-green
  - all-red clearance interval
  - flashing-yellow fault/maintenance mode
- Sits between detector/request logic and the lamp drivers.

Parameters:
- NUM_DIR, 4, number of approaches (2..8).
- TW, 8, timer width in bits. Every duration must be ≤ 2^TW.
- GREEN_T, 20, minimum green duration in cycles (≥1).
- YELLOW_T, 3, yellow duration in cycles (≥1).
- ALLRED_T, 2, all-red clearance duration in cycles (≥1).
- FLASH_T, 10, half-period of the flashing yellow in cycles (≥1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  leave IDLE and begin operation. Sampled only in IDLE.
- flash  input  1  level: force flashing-yellow mode.
- req  input  NUM_DIR  per-approach demand, level-sensitive.
- red  output  NUM_DIR  red lamp per approach.
- yellow  output  NUM_DIR  yellow lamp per approach.
- green  output  NUM_DIR  green lamp per approach.
- active_dir  output  $clog2(NUM_DIR)  approach currently owning right-of-way (cur).
- busy  output  1  high in every state except IDLE.

Behaviour:
- States: IDLE, ALLRED, GREEN, YELLOW, FLASH.
- State, timer, cur and flash phase are registered.
- Lamps, active_dir and busy are a pure decode of those registers. There is no combinational path from any input to any output.
- Lamp decode:
  - IDLE: all lamps 0, busy 0.
  - ALLRED: red all 1.
  - GREEN: green[cur]=1, red on all others.
  - YELLOW: yellow[cur]=1, red on all others.
  - FLASH: red=0, green=0, yellow = all-ones when phase=1, else 0.
- Reset (reset=0 at a clock edge):
  - state=IDLE, timer=0, cur=NUM_DIR-1, phase=0.
  - Outputs: all lamps 0, busy 0, active_dir=NUM_DIR-1.
  - Applies from any state, including mid-interval.
- Input priority every cycle: reset > flash > normal transitions.
- Timer:
  - Cleared to 0 on every state entry.
  - Increments each cycle while in the state.
- IDLE:
  - start=1 -> ALLRED.
  - start is ignored in every other state.
- ALLRED:
  - Lasts exactly ALLRED_T cycles, then goes to GREEN.
  - On that transition, cur <= first index i with req[i]=1, searching from cur+1 upward modulo NUM_DIR.
  - If no req is set, cur <= (cur+1) mod NUM_DIR.
- GREEN:
  - Timer saturates at GREEN_T-1.
  - Goes to YELLOW at the first edge where timer==GREEN_T-1 and some req[j]=1 with j≠cur.
  - Otherwise it holds green indefinitely (rest-in-green).
  - Earliest exit: GREEN_T cycles after entry.
- YELLOW: lasts exactly YELLOW_T cycles, then goes to ALLRED.
- FLASH entry and toggling:
  - flash=1 in any state, IDLE included, goes to FLASH at the next edge.
  - On entry phase=1 and timer=0.
  - Phase toggles every FLASH_T cycles.
  - While flash stays high, the block remains in FLASH.
- FLASH exit:
  - flash=0 goes to ALLRED at the next edge. cur is preserved.
  - Normal clearance then follows; no direct exit to GREEN is permitted.
- Safety invariants, every cycle:
  - At most one green bit set.
  - Never green and yellow on the same approach.
  - Never green[i] while red[i]=1.
  - Every GREEN is preceded by ALLRED.
- Width rules: cur arithmetic is modulo NUM_DIR; timer comparisons are unsigned TW-bit.

Test Plan:
All tests use NUM_DIR=4, GREEN_T=4, YELLOW_T=2, ALLRED_T=1, FLASH_T=2.
1. Reset held low 2 cycles, then released with start=0 -> state IDLE, red/yellow/green=0000, busy=0, active_dir=3. Outputs stay so for 10 cycles.
2. start pulse with req=1111 -> expected lamp sequence:
   - 1 cycle red=1111
   - 4 cycles green=0001 / red=1110
   - 2 cycles yellow=0001 / red=1110
   - 1 cycle red=1111
   - then green=0010
   - continues cycling through 2, 3, then wraps to 0 after dir 3.
3. req=0100 only, then start -> green=0100 after ALLRED. It holds past 4 cycles (rest-in-green). Raising req to 0101 gives yellow=0100 on the next edge, then all-red for 1 cycle, then green=0001 (wrap search from 3).
4. Skip: cur=1 in GREEN, req=1001 -> after yellow and all-red, green=1000. Approach 2 is skipped.
5. flash=1 asserted mid-GREEN -> next cycle red=0000, green=0000, yellow=1111 for 2 cycles, then 0000 for 2 cycles, repeating. Deasserting flash gives red=1111 for 1 cycle, then GREEN on the next approach selected by the normal search rule.
6. reset=0 for one edge during YELLOW -> IDLE, all lamps 0, busy 0. A following start yields ALLRED, then green on the first requested approach searching from 0.
